// File: rtl/fetch_queue.sv
// In-order instruction fetch with a DEPTH-entry buffer; fetch-to-decode latency = memory latency + 1.
// New requests stop when buffered plus in-flight work would overflow the buffer or MAX_OUT is reached.
module fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [31:0] pc_i,
  output logic        pc_hold_o,
  input  logic        flush_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  localparam logic [PW-1:0] PTR_ONE  = 1;
  localparam logic [CW-1:0] CNT_ONE  = 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [OW-1:0] OUT_ONE  = 1;
  localparam logic [TW-1:0] TAG_ONE  = 1;
  localparam logic [TW-1:0] TAG_LAST = TW'(MAX_OUT - 1);

  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   inst_mem_d [DEPTH];
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   pc_mem_d   [DEPTH];
  logic [31:0]   tag_mem_q  [MAX_OUT];
  logic [31:0]   tag_mem_d  [MAX_OUT];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [OW-1:0] out_q, out_d, drop_q, drop_d;
  logic [TW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

  logic [31:0] occupancy;
  logic        cap_ok, accept, rsp, push, pop;

  always_comb begin
    occupancy = 32'(count_q) + 32'(out_q);
    cap_ok    = (occupancy < 32'(DEPTH)) && (32'(out_q) < 32'(MAX_OUT));
  end

  // Reset gating keeps the request low even if start_i is held high through reset.
  assign imem_req_o   = rst_n_i & start_i & ~flush_i & cap_ok;
  assign imem_addr_o  = pc_i;
  assign accept       = imem_req_o & imem_gnt_i;
  assign pc_hold_o    = ~accept;
  assign rsp          = imem_rvalid_i && (out_q != '0);
  assign push         = rsp && (drop_q == '0) && !flush_i;
  assign inst_valid_o = (count_q != '0);
  assign pop          = inst_valid_o && inst_ready_i && !flush_i;
  assign inst_o       = inst_mem_q[rd_ptr_q];
  assign inst_pc_o    = pc_mem_q[rd_ptr_q];

  always_comb begin
    inst_mem_d = inst_mem_q;
    pc_mem_d   = pc_mem_q;
    tag_mem_d  = tag_mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    out_d      = out_q;
    drop_d     = drop_q;
    tag_rd_d   = tag_rd_q;
    tag_wr_d   = tag_wr_q;

    if (accept && !rsp)      out_d = out_q + OUT_ONE;
    else if (!accept && rsp) out_d = out_q - OUT_ONE;

    // Tags pop on every response, dropped or not, so the queue is empty once draining ends.
    if (accept) begin
      tag_mem_d[tag_wr_q] = pc_i;
      tag_wr_d = (tag_wr_q == TAG_LAST) ? '0 : tag_wr_q + TAG_ONE;
    end
    if (rsp) tag_rd_d = (tag_rd_q == TAG_LAST) ? '0 : tag_rd_q + TAG_ONE;

    if (flush_i)                   drop_d = out_d;
    else if (rsp && drop_q != '0)  drop_d = drop_q - OUT_ONE;

    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        inst_mem_d[wr_ptr_q] = imem_rdata_i;
        pc_mem_d[wr_ptr_q]   = tag_mem_q[tag_rd_q];
        wr_ptr_d             = wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (!push && pop) count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
      for (int i = 0; i < MAX_OUT; i++) tag_mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      out_q    <= '0;
      drop_q   <= '0;
      tag_rd_q <= '0;
      tag_wr_q <= '0;
    end else begin
      inst_mem_q <= inst_mem_d;
      pc_mem_q   <= pc_mem_d;
      tag_mem_q  <= tag_mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
    end
  end

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    push |-> (count_q != CNT_FULL));
  a_no_stray_rsp: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    imem_rvalid_i |-> (out_q != '0));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: PC register and memory models drive the DUT, a monitor checks IF/ID output order.
module tb_fetch_queue;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic        pc_hold_o;
  logic        flush_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i = 1'b0;

  fetch_queue #(.DEPTH(4), .MAX_OUT(2)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .pc_i(pc_i), .pc_hold_o(pc_hold_o),
    .flush_i(flush_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .inst_valid_o(inst_valid_o),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_ready_i(inst_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          lat = 1;

  logic        s_req, s_hold, s_valid;
  logic [31:0] s_addr, s_pc, s_inst;

  function automatic logic [31:0] inst_of(logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One clock: sample at the falling edge, then advance the PC/memory models just after the rising edge.
  task automatic cycle();
    logic acc;
    @(negedge clk_i);
    s_req   = imem_req_o;
    s_addr  = imem_addr_o;
    s_hold  = pc_hold_o;
    s_valid = inst_valid_o;
    s_pc    = inst_pc_o;
    s_inst  = inst_o;
    acc     = imem_req_o & imem_gnt_i;
    if (imem_rvalid_i && mq.size() > 0) void'(mq.pop_front());
    if (acc) begin
      mq.push_back('{addr: imem_addr_o, due: cyc + lat});
      exp_q.push_back(imem_addr_o);
    end
    if (flush_i) exp_q.delete();
    @(posedge clk_i);
    #1;
    cyc++;
    if (acc) pc_i = pc_i + 32'd4;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = inst_of(mq[0].addr);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
    end
  endtask

  task automatic wait_valid(string name, logic [31:0] exp_pc);
    int n = 0;
    cycle();
    while (!s_valid && n < 20) begin
      cycle();
      n++;
    end
    chk({name, "_valid"}, 32'(s_valid), 32'd1);
    chk({name, "_pc"}, s_pc, exp_pc);
    chk({name, "_inst"}, s_inst, inst_of(exp_pc));
  endtask

  task automatic drain(string name);
    start_i      = 1'b0;
    inst_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk({name, "_no_req"}, 32'(s_req), 32'd0);
    end
    chk({name, "_empty"}, 32'(s_valid), 32'd0);
  endtask

  // Scoreboard monitor: every handshake at IF/ID must match the oldest expected PC.
  always @(negedge clk_i) begin
    if (rst_n_i && inst_valid_o && inst_ready_i && !flush_i) begin
      if (exp_q.size() == 0) begin
        chk("mon_unexpected_pop", inst_pc_o, 32'hFFFF_FFFF);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("mon_pc", inst_pc_o, e);
        chk("mon_inst", inst_o, inst_of(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    // Test 1: reset values, then first fetch through a 1-cycle memory.
    #2 rst_n_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_valid", 32'(inst_valid_o), 32'd0);
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_hold", 32'(pc_hold_o), 32'd1);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_inst_pc", inst_pc_o, 32'd0);
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1; start_i = 1'b1; imem_gnt_i = 1'b1; inst_ready_i = 1'b1; pc_i = 32'h0;
    cycle();
    chk("t1_req", 32'(s_req), 32'd1);
    chk("t1_addr", s_addr, 32'h0);
    chk("t1_hold", 32'(s_hold), 32'd0);
    cycle();
    chk("t1_no_bypass", 32'(s_valid), 32'd0);
    cycle();
    chk("t1_valid", 32'(s_valid), 32'd1);
    chk("t1_pc", s_pc, 32'h0);

    // Test 2: streaming, one instruction per cycle.
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("t2_hold", 32'(s_hold), 32'd0);
      chk("t2_valid", 32'(s_valid), 32'd1);
    end

    // Test 3: decode stall fills the buffer and stops requests.
    inst_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("t3_valid", 32'(s_valid), 32'd1);
      chk("t3_head_pc", s_pc, exp_q[0]);
      chk("t3_head_inst", s_inst, inst_of(exp_q[0]));
      if (i >= 3) begin
        chk("t3_req_low", 32'(s_req), 32'd0);
        chk("t3_hold", 32'(s_hold), 32'd1);
      end
    end
    inst_ready_i = 1'b1;
    repeat (6) cycle();
    drain("t3_drain");

    // Test 4: flush with two in flight on a 3-cycle memory and two buffered.
    lat = 3; inst_ready_i = 1'b0; start_i = 1'b1; pc_i = 32'h100;
    repeat (6) cycle();
    chk("t4_pre_valid", 32'(inst_valid_o), 32'd1);
    flush_i = 1'b1; pc_i = 32'h40;
    cycle();
    chk("t4_flush_req", 32'(s_req), 32'd0);
    flush_i = 1'b0; inst_ready_i = 1'b1;
    cycle();
    chk("t4_after_flush_valid", 32'(s_valid), 32'd0);
    wait_valid("t4_first", 32'h40);
    repeat (4) cycle();
    drain("t4_drain");

    // Test 5: grant withheld for five cycles.
    lat = 1; start_i = 1'b1; imem_gnt_i = 1'b0; pc_i = 32'h200;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t5_req", 32'(s_req), 32'd1);
      chk("t5_addr", s_addr, 32'h200);
      chk("t5_hold", 32'(s_hold), 32'd1);
      chk("t5_valid", 32'(s_valid), 32'd0);
    end
    imem_gnt_i = 1'b1;
    wait_valid("t5_first", 32'h200);
    drain("t5_drain");

    // Test 6: async reset with three buffered and one in flight.
    lat = 1; inst_ready_i = 1'b0; start_i = 1'b1; pc_i = 32'h300;
    repeat (4) cycle();
    chk("t6_pre_valid", 32'(inst_valid_o), 32'd1);
    #2;
    rst_n_i = 1'b0;
    imem_rvalid_i = 1'b0;
    mq.delete();
    exp_q.delete();
    #1;
    chk("t6_rst_valid", 32'(inst_valid_o), 32'd0);
    chk("t6_rst_req", 32'(imem_req_o), 32'd0);
    chk("t6_rst_hold", 32'(pc_hold_o), 32'd1);
    chk("t6_rst_inst", inst_o, 32'd0);
    chk("t6_rst_inst_pc", inst_pc_o, 32'd0);
    cycle();
    cycle();
    rst_n_i = 1'b1; start_i = 1'b0; inst_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t6_post_valid", 32'(s_valid), 32'd0);
      chk("t6_post_req", 32'(s_req), 32'd0);
    end
    start_i = 1'b1; pc_i = 32'h400;
    wait_valid("t6_first", 32'h400);
    drain("t6_drain");

    chk("end_all_delivered", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
